axis_fifo_rd_if: RTL and testbench
==================================

Name: axis_fifo_rd_if

Overview:
- AXI-Stream master adapter for the read port of the async FIFO core. Runs entirely in the read clock domain.
- Drains words from the FIFO's show-ahead read port (rdata valid whenever empty is low, consumed by ren) into a 2-entry registered output buffer.
- Presents them as m_axis_tdata/tlast/tvalid with full throughput.
- No combinational path from m_axis_tready to fifo_ren or to any output.

Parameters:
- DW, 8, AXIS payload width. FIFO word width is DW+1; bit DW carries tlast.

Ports:
- clk  input  1  read-domain clock
- rst  input  1  reset, asynchronous, active-low
- fifo_empty  input  1  FIFO core empty flag
- fifo_rdata  input  DW+1  FIFO show-ahead read data, {tlast, tdata}
- fifo_ren  output  1  FIFO read enable; pops the current word at the next clk edge
- m_axis_tvalid  output  1  output word valid
- m_axis_tready  input  1  downstream ready
- m_axis_tdata  output  DW  output payload
- m_axis_tlast  output  1  end-of-packet marker
- buf_level  output  2  number of words held in the output buffer (0..2)

Behaviour:
- Reset (rst low, asynchronous):
  - buf_level=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Both buffer entries cleared to 0.
  - Outputs hold while reset is asserted. Normal operation starts on the first clk edge after rst deasserts.
- Buffer structure:
  - Two registers, head and tail, plus a level counter of 0, 1 or 2.
  - m_axis_tdata/tlast are driven directly from head. m_axis_tvalid = (level != 0), decoded from a registered flag.
- Fetch rule: fifo_ren = !fifo_empty && (level < 2). This is combinational on registered level and fifo_empty only; it never depends on m_axis_tready.
- Events per edge: push = fifo_ren; pop = m_axis_tvalid && m_axis_tready.
  - level 0, push: head <= fifo_rdata, level becomes 1.
  - level 1, push only: tail <= fifo_rdata, level becomes 2.
  - level 1, pop only: level becomes 0; head retains its stale value.
  - level 1, push and pop: head <= fifo_rdata, level stays 1.
  - level 2, pop: head <= tail, level becomes 1. Push is impossible at level 2.
  - No event: hold.
- Latency: fifo_empty falls in cycle N with level 0 → fifo_ren=1 in cycle N → m_axis_tvalid=1 from cycle N+1. First-word latency is 1 clk.
- Throughput: with tready held at 1 and the FIFO non-empty, steady state is level=1 with one push and one pop per cycle (100%).
- AXIS rules:
  - Once tvalid=1, tdata and tlast are stable until a handshake.
  - tvalid never drops without a handshake.
  - Word order is strictly FIFO; tlast travels with its word.
- Stall: tready=0 fills the buffer to level 2, then fifo_ren=0 until a pop.
- FIFO empty while buffered words remain: output continues draining; tvalid drops after the last pop.
- Reset mid-operation:
  - Buffered words are discarded and tvalid drops immediately (asynchronously).
  - FIFO pointers are reset separately by the read-domain reset; this block issues no ren while rst is low.
- buf_level is a registered value and equals the internal level counter.

Test Plan:
- Reset: hold rst low with fifo_empty=0, rdata=9'h1AA → fifo_ren=0, tvalid=0, tdata=8'h00, buf_level=0. Release rst → fifo_ren=1 in that cycle; tvalid=1 with tdata=8'hAA one edge later.
- Streaming: FIFO supplies 0x01..0x10, tready=1 → 16 consecutive handshakes with no bubble, in order. buf_level stays 1 during the burst, 0 after.
- Backpressure: tready=0 while FIFO holds 0x21,0x22,0x23 → buf_level reaches 2, fifo_ren=0, tdata holds 0x21. Raise tready → 0x21, 0x22, 0x23 emitted on consecutive cycles with no loss or duplication.
- tlast: FIFO words {0,0x10},{0,0x11},{1,0x12} with random tready → tlast=1 only on 0x12; tdata/tlast stable across stalled cycles.
- Empty-gap: single word 0x5A, then FIFO empty for 3 cycles, then 0x5B → tvalid deasserts after 0x5A handshakes; 0x5B appears 1 cycle after fifo_empty falls.
- Mid-stream reset: at buf_level=2, pulse rst low between clk edges → tvalid and buf_level go to 0 before the next edge; after release, only new FIFO words are emitted.

Source files
------------

// File: rtl/axis_fifo_rd_if.sv
// AXI-Stream master adapter draining the async FIFO's show-ahead read port.
// Latency: 1 clk from fifo_empty falling to m_axis_tvalid; full throughput when tready stays high.
// Backpressure: a 2-entry output buffer absorbs stalls; fifo_ren depends only on registered level and fifo_empty.
module axis_fifo_rd_if #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic [DW:0]   fifo_rdata,
    output logic          fifo_ren,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tlast,
    output logic [1:0]    buf_level
);

    logic [DW:0] head_q, head_d;
    logic [DW:0] tail_q, tail_d;
    logic [1:0]  level_q, level_d;
    logic        vld_q, vld_d;
    logic        push;
    logic        pop;

    // Gating with rst keeps the FIFO pointers untouched while reset is held.
    assign fifo_ren = rst & ~fifo_empty & (level_q < 2'd2);
    assign push     = fifo_ren;
    assign pop      = vld_q & m_axis_tready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        case (level_q)
            2'd0: begin
                if (push) begin
                    head_d  = fifo_rdata;
                    level_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = fifo_rdata;
                end else if (push) begin
                    tail_d  = fifo_rdata;
                    level_d = 2'd2;
                end else if (pop) begin
                    level_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    level_d = 2'd1;
                end
            end
            default: level_d = 2'd0;
        endcase
        vld_d = (level_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= 2'd0;
            vld_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            vld_q   <= vld_d;
        end
    end

    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = head_q[DW-1:0];
    assign m_axis_tlast  = head_q[DW];
    assign buf_level     = level_q;

endmodule

// File: tb/tb_axis_fifo_rd_if.sv
`timescale 1ns/1ps
module tb_axis_fifo_rd_if;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW:0]   fifo_rdata = '0;
    logic          m_axis_tready = 1'b0;
    logic          fifo_ren;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic [1:0]    buf_level;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    logic [DW:0] fifo_q[$];
    logic [DW:0] exp_q[$];

    always #5 clk = ~clk;

    axis_fifo_rd_if #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_ren     (fifo_ren),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .buf_level    (buf_level)
    );

    task automatic put(input logic [DW:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    // One clock: sample mid-cycle, let the edge happen, then update the FIFO model.
    task automatic cyc();
        logic        ren;
        logic        hs;
        logic [DW:0] got;
        logic [DW:0] tmp;
        #1;
        ren = fifo_ren;
        hs  = m_axis_tvalid && m_axis_tready;
        got = {m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_word got=%h but scoreboard empty", got);
            end else if (got !== exp_q[0]) begin
                failures++;
                $display("FAIL out_word got=%h exp=%h", got, exp_q[0]);
            end
        end
        @(posedge clk);
        #1;
        if (ren && fifo_q.size() > 0) tmp = fifo_q.pop_front();
        if (hs) begin
            hs_cnt++;
            if (exp_q.size() > 0) tmp = exp_q.pop_front();
        end
        drive_fifo();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() > 0 && n < max) begin
            cyc();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        m_axis_tready = 1'b0;
        #3 rst = 1'b0;
        put(9'h1AA);
        drive_fifo();
        #4;
        checks++;
        if (fifo_ren !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 ||
            m_axis_tlast !== 1'b0 || buf_level !== 2'd0) begin
            failures++;
            $display("FAIL reset_state ren=%b vld=%b data=%h last=%b lvl=%0d exp 0/0/00/0/0",
                     fifo_ren, m_axis_tvalid, m_axis_tdata, m_axis_tlast, buf_level);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (fifo_ren !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ren got=%b exp=1", fifo_ren);
        end
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hAA || m_axis_tlast !== 1'b1 || buf_level !== 2'd1) begin
            failures++;
            $display("FAIL first_word vld=%b data=%h last=%b lvl=%0d exp 1/aa/1/1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, buf_level);
        end
        m_axis_tready = 1'b1;
        drain(10);
    endtask

    task automatic test_streaming();
        int hs0;
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 16; i++) put({1'b0, 8'(i)});
        drive_fifo();
        cyc();
        hs0 = hs_cnt;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || buf_level !== 2'd1) begin
                failures++;
                $display("FAIL stream_cycle%0d vld=%b lvl=%0d exp 1/1", i, m_axis_tvalid, buf_level);
            end
            cyc();
        end
        checks++;
        if (hs_cnt - hs0 != 16 || buf_level !== 2'd0 || m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stream_end hs=%0d lvl=%0d vld=%b left=%0d exp 16/0/0/0",
                     hs_cnt - hs0, buf_level, m_axis_tvalid, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int hs0;
        m_axis_tready = 1'b0;
        put(9'h021); put(9'h022); put(9'h023);
        drive_fifo();
        cyc();
        cyc();
        checks++;
        if (buf_level !== 2'd2 || fifo_ren !== 1'b0 || m_axis_tdata !== 8'h21) begin
            failures++;
            $display("FAIL bp_full lvl=%0d ren=%b data=%h exp 2/0/21", buf_level, fifo_ren, m_axis_tdata);
        end
        cyc();
        checks++;
        if (buf_level !== 2'd2 || m_axis_tdata !== 8'h21) begin
            failures++;
            $display("FAIL bp_hold lvl=%0d data=%h exp 2/21", buf_level, m_axis_tdata);
        end
        m_axis_tready = 1'b1;
        hs0 = hs_cnt;
        cyc(); cyc(); cyc();
        checks++;
        if (hs_cnt - hs0 != 3 || buf_level !== 2'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_release hs=%0d lvl=%0d left=%0d exp 3/0/0", hs_cnt - hs0, buf_level, exp_q.size());
        end
    endtask

    task automatic test_tlast();
        put(9'h010); put(9'h011); put(9'h112);
        drive_fifo();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            cyc();
        end
        m_axis_tready = 1'b1;
        drain(10);
    endtask

    task automatic test_empty_gap();
        m_axis_tready = 1'b1;
        put(9'h05A);
        drive_fifo();
        cyc();
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b0 || buf_level !== 2'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL gap_drop vld=%b lvl=%0d left=%0d exp 0/0/0", m_axis_tvalid, buf_level, exp_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (m_axis_tvalid !== 1'b0 || fifo_ren !== 1'b0) begin
                failures++;
                $display("FAIL gap_idle%0d vld=%b ren=%b exp 0/0", i, m_axis_tvalid, fifo_ren);
            end
        end
        put(9'h05B);
        drive_fifo();
        #1;
        checks++;
        if (fifo_ren !== 1'b1) begin
            failures++;
            $display("FAIL gap_ren got=%b exp=1", fifo_ren);
        end
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h5B) begin
            failures++;
            $display("FAIL gap_second vld=%b data=%h exp 1/5b", m_axis_tvalid, m_axis_tdata);
        end
        drain(5);
    endtask

    task automatic test_mid_reset();
        m_axis_tready = 1'b0;
        put(9'h031); put(9'h032); put(9'h033);
        drive_fifo();
        cyc();
        cyc();
        checks++;
        if (buf_level !== 2'd2) begin
            failures++;
            $display("FAIL mrst_fill lvl=%0d exp=2", buf_level);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || buf_level !== 2'd0 || fifo_ren !== 1'b0 || m_axis_tdata !== 8'h00) begin
            failures++;
            $display("FAIL mrst_async vld=%b lvl=%0d ren=%b data=%h exp 0/0/0/00",
                     m_axis_tvalid, buf_level, fifo_ren, m_axis_tdata);
        end
        fifo_q.delete();
        exp_q.delete();
        put(9'h041);
        put(9'h142);
        drive_fifo();
        #1 rst = 1'b1;
        m_axis_tready = 1'b1;
        drain(10);
        cyc();
        checks++;
        if (buf_level !== 2'd0 || m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL mrst_end lvl=%0d vld=%b exp 0/0", buf_level, m_axis_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_tlast();
        test_empty_gap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
